// File: rtl/conv_pipe_sched.sv
// conv_pipe_sched: handshake and pipeline scheduler for a streaming 1-D convolution.
// Loads F_SIZE filter coefficients and streams X_SIZE samples through a sliding
// window. Each completed window becomes a token travelling down a PLINE_STAGES deep
// valid pipeline toward the y output. A stalled y output freezes the whole pipeline.
// Optional feature: define CONV_PIPE_SCHED_STALL_CNT_EN to add the stall_cycles
// output, which counts the cycles where the y output is held off by its consumer.
module conv_pipe_sched #(
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int PLINE_STAGES = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid_x,
  output logic                      s_ready_x,
  input  logic                      s_valid_f,
  output logic                      s_ready_f,
  output logic                      xmem_wr_en,
  output logic                      fmem_wr_en,
  output logic [$clog2(F_SIZE)-1:0] fmem_addr,
  output logic                      en_pline_stages,
  output logic                      m_valid_y,
  input  logic                      m_ready_y,
  output logic                      conv_done
`ifdef CONV_PIPE_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cycles
`endif
);

  localparam int AW      = $clog2(F_SIZE);
  localparam int FCW     = $clog2(F_SIZE + 1);
  localparam int XCW     = $clog2(X_SIZE + 1);
  localparam int Y_TOTAL = X_SIZE - F_SIZE + 1;
  localparam int YCW     = $clog2(Y_TOTAL + 1);

  localparam logic [FCW-1:0] F_FULL = FCW'(F_SIZE);
  localparam logic [FCW-1:0] F_LAST = FCW'(F_SIZE - 1);
  localparam logic [XCW-1:0] X_FULL = XCW'(X_SIZE);
  localparam logic [XCW-1:0] X_LAST = XCW'(X_SIZE - 1);
  // Samples the window can hold before the coefficients are complete; also the
  // pre-increment count from which every accepted sample completes a window.
  localparam logic [XCW-1:0] X_WIN  = XCW'(F_SIZE - 1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(Y_TOTAL - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic [XCW-1:0]          xcnt_q, xcnt_d;
  logic [YCW-1:0]          ycnt_q, ycnt_d;
  logic                    win_new_q, win_new_d;
  logic [PLINE_STAGES-1:0] vld_q, vld_d;

  logic rst_meta_q, rst_sync_q;
  logic hold_off;
  logic y_hs;
  logic win_set;

  // Reset synchronizer: assertion is immediate, release waits two clock edges.
  // NOTE: the external reset goes straight to the synchronizer only; all other state
  // is cleared by its output, so every flop leaves reset on the same clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Between reset release and synchronizer release the FSM is still frozen, so the
  // input handshakes are closed to avoid accepting data that would be dropped.
  assign hold_off = reset & ~rst_sync_q;

  // Output side of the pipeline: the last valid stage drives y, and a stalled y
  // freezes every stage. Held low while the FSM is in reset so the pipeline is idle.
  assign m_valid_y       = vld_q[PLINE_STAGES-1];
  assign en_pline_stages = rst_sync_q & ~(m_valid_y & ~m_ready_y);
  assign y_hs            = m_valid_y & m_ready_y;

  // Input readiness, coefficient address and done pulse, decoded from the state.
  // NOTE: every output of a combinational block gets a default first so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    s_ready_x = 1'b0;
    s_ready_f = 1'b0;
    fmem_addr = '0;
    conv_done = 1'b0;
    unique case (state_q)
      LOAD: begin
        s_ready_f = (fcnt_q < F_FULL);
        s_ready_x = (xcnt_q < X_WIN);
        fmem_addr = fcnt_q[AW-1:0];
      end
      RUN: begin
        // A completed window may only be replaced once the pipeline has taken it.
        s_ready_x = (xcnt_q < X_FULL) && (!win_new_q || en_pline_stages);
      end
      DRAIN: begin
      end
      DONE: begin
        conv_done = 1'b1;
      end
    endcase
    if (hold_off) begin
      s_ready_x = 1'b0;
      s_ready_f = 1'b0;
    end
  end

  assign xmem_wr_en = s_valid_x & s_ready_x;
  assign fmem_wr_en = s_valid_f & s_ready_f;
  assign win_set    = xmem_wr_en && (xcnt_q >= X_WIN);

  // Next-state logic: counters, window flag, valid pipeline and FSM transitions.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    xcnt_d    = xcnt_q;
    ycnt_d    = ycnt_q;
    win_new_d = win_new_q;
    vld_d     = vld_q;

    if (fmem_wr_en) fcnt_d = fcnt_q + FCW'(1);
    if (xmem_wr_en) xcnt_d = xcnt_q + XCW'(1);
    if (y_hs)       ycnt_d = ycnt_q + YCW'(1);

    // A new window wins over the capture of the previous one in the same cycle.
    if (win_set) begin
      win_new_d = 1'b1;
    end else if (en_pline_stages) begin
      win_new_d = 1'b0;
    end

    if (en_pline_stages) begin
      vld_d[0] = win_new_q;
      for (int i = 1; i < PLINE_STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end

    unique case (state_q)
      LOAD: begin
        if (fmem_wr_en && (fcnt_q == F_LAST)) state_d = RUN;
      end
      RUN: begin
        if (xmem_wr_en && (xcnt_q == X_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (y_hs && (ycnt_q == Y_LAST)) state_d = DONE;
      end
      DONE: begin
        state_d   = LOAD;
        fcnt_d    = '0;
        xcnt_d    = '0;
        ycnt_d    = '0;
        win_new_d = 1'b0;
        vld_d     = '0;
      end
    endcase
  end

  // State register for the FSM, counters and pipeline valid bits.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= LOAD;
      fcnt_q    <= '0;
      xcnt_q    <= '0;
      ycnt_q    <= '0;
      win_new_q <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      xcnt_q    <= xcnt_d;
      ycnt_q    <= ycnt_d;
      win_new_q <= win_new_d;
      vld_q     <= vld_d;
    end
  end

`ifdef CONV_PIPE_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a y is offered but not taken; per frame.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == DONE) begin
      stall_cnt_d = '0;
    end else if (m_valid_y && !m_ready_y && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
